// File: rtl/wb_ram_ctrl_if.sv
// Wishbone classic-cycle bus bundle between a master and the RAM controller.
// The master drives the request side; the slave returns data, ack and err.
interface wb_ram_ctrl_if #(
  parameter int DAT_WIDTH = 32,
  parameter int ADR_WIDTH = 10,
  parameter int SEL_WIDTH = DAT_WIDTH / 8
);
  logic                 wb_cyc_i;
  logic                 wb_stb_i;
  logic                 wb_we_i;
  logic [SEL_WIDTH-1:0] wb_sel_i;
  logic [ADR_WIDTH+1:0] wb_adr_i;
  logic [DAT_WIDTH-1:0] wb_dat_i;
  logic [DAT_WIDTH-1:0] wb_dat_o;
  logic                 wb_ack_o;
  logic                 wb_err_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
    input  wb_dat_o, wb_ack_o, wb_err_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
    output wb_dat_o, wb_ack_o, wb_err_o
  );
endinterface

// File: rtl/wb_ram_ctrl.sv
// Wishbone slave in front of a single-port synchronous RAM: hides the RAM read
// latency, performs byte-select writes by read-modify-write and flags out-of-range words.
module wb_ram_ctrl #(
  parameter int DAT_WIDTH = 32,
  parameter int ADR_WIDTH = 10,
  parameter int MEM_SIZE  = 1024,
  parameter int SEL_WIDTH = DAT_WIDTH / 8
) (
  input  logic                 clk,
  input  logic                 rst,
  wb_ram_ctrl_if.slave         wb,
  output logic [ADR_WIDTH-1:0] ram_adr_o,
  output logic [DAT_WIDTH-1:0] ram_dat_o,
  output logic                 ram_we_o,
  input  logic [DAT_WIDTH-1:0] ram_dat_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    ACK  = 2'd2
  } state_t;

  localparam logic [ADR_WIDTH:0] MEM_LIMIT = MEM_SIZE[ADR_WIDTH:0];

  state_t               state_r;
  state_t               state_nxt_s;
  logic                 ack_r;
  logic                 ack_nxt_s;
  logic                 err_r;
  logic                 err_nxt_s;
  logic [DAT_WIDTH-1:0] dat_r;
  logic [DAT_WIDTH-1:0] dat_nxt_s;
  logic                 ram_we_s;
  logic [DAT_WIDTH-1:0] ram_dat_s;
  logic [ADR_WIDTH-1:0] word_adr_s;
  logic                 req_s;
  logic                 in_range_s;
  logic                 sel_full_s;
  logic                 sel_none_s;
  logic                 adr_unused_s;

  // Lane i comes from the new data when selected, otherwise from the RAM word.
  function automatic logic [DAT_WIDTH-1:0] merge_bytes(
    input logic [DAT_WIDTH-1:0] new_dat,
    input logic [DAT_WIDTH-1:0] old_dat,
    input logic [SEL_WIDTH-1:0] sel
  );
    logic [DAT_WIDTH-1:0] m;
    m = old_dat;
    for (int i = 0; i < SEL_WIDTH; i++) begin
      if (sel[i]) begin
        m[8*i +: 8] = new_dat[8*i +: 8];
      end else begin
        m[8*i +: 8] = old_dat[8*i +: 8];
      end
    end
    return m;
  endfunction

  assign word_adr_s   = wb.wb_adr_i[ADR_WIDTH+1:2];
  assign adr_unused_s = ^wb.wb_adr_i[1:0];
  assign req_s        = wb.wb_cyc_i & wb.wb_stb_i;
  assign in_range_s   = ({1'b0, word_adr_s} < MEM_LIMIT);
  assign sel_full_s   = &wb.wb_sel_i;
  assign sel_none_s   = ~|wb.wb_sel_i;

  // The RAM samples the live bus address; RD relies on the master holding it stable.
  assign ram_adr_o = word_adr_s;
  assign ram_dat_o = ram_dat_s;
  assign ram_we_o  = ram_we_s & ~rst;

  assign wb.wb_ack_o = ack_r;
  assign wb.wb_err_o = err_r;
  assign wb.wb_dat_o = dat_r;

  // State register and registered bus responses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      ack_r   <= 1'b0;
      err_r   <= 1'b0;
      dat_r   <= {DAT_WIDTH{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      ack_r   <= ack_nxt_s;
      err_r   <= err_nxt_s;
      dat_r   <= dat_nxt_s;
    end
  end

  // Next-state, RAM write strobe and response decode.
  always_comb begin
    state_nxt_s = state_r;
    ack_nxt_s   = 1'b0;
    err_nxt_s   = 1'b0;
    dat_nxt_s   = dat_r;
    ram_we_s    = 1'b0;
    ram_dat_s   = wb.wb_dat_i;
    case (state_r)
      IDLE: begin
        if (!req_s) begin
          state_nxt_s = IDLE;
        end else if (!in_range_s) begin
          err_nxt_s   = 1'b1;
          state_nxt_s = ACK;
        end else if (wb.wb_we_i && sel_full_s) begin
          ram_we_s    = 1'b1;
          ack_nxt_s   = 1'b1;
          state_nxt_s = ACK;
        end else if (wb.wb_we_i && sel_none_s) begin
          ack_nxt_s   = 1'b1;
          state_nxt_s = ACK;
        end else begin
          state_nxt_s = RD;
        end
      end
      RD: begin
        if (!wb.wb_cyc_i) begin
          state_nxt_s = IDLE;
        end else if (wb.wb_we_i) begin
          ram_we_s    = 1'b1;
          ram_dat_s   = merge_bytes(wb.wb_dat_i, ram_dat_i, wb.wb_sel_i);
          ack_nxt_s   = 1'b1;
          state_nxt_s = ACK;
        end else begin
          dat_nxt_s   = ram_dat_i;
          ack_nxt_s   = 1'b1;
          state_nxt_s = ACK;
        end
      end
      ACK: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

endmodule
